// File: rtl/rgb_frame_seq_if.sv
// Pixel RAM read port and RGBW FIFO write port as seen by rgb_frame_seq.
// The sequencer uses the master modport; the RAM/FIFO side uses slave.
interface rgb_frame_seq_if #(
    parameter int ADDR_W = 8
);
    logic              out_pix_rd_en;
    logic [ADDR_W-1:0] out_pix_addr;
    logic [23:0]       in_pix_data;
    logic              in_wr_fifo_full;
    logic              out_wr_fifo_en;
    logic [31:0]       out_wr_fifo_data;

    modport master (
        output out_pix_rd_en, out_pix_addr, out_wr_fifo_en, out_wr_fifo_data,
        input  in_pix_data, in_wr_fifo_full
    );

    modport slave (
        input  out_pix_rd_en, out_pix_addr, out_wr_fifo_en, out_wr_fifo_data,
        output in_pix_data, in_wr_fifo_full
    );
endinterface

// File: rtl/rgb_frame_seq.sv
// Frame sequencer: pixel RAM -> RGBW FIFO words plus a stream-reset word per frame.
// Optional test-pattern source is enabled with `define FSEQ_TEST_PATTERN_EN.
module rgb_frame_seq #(
    parameter int ADDR_W     = 8,
    parameter int FRAME_CLKS = 1600000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_enable,
    input  logic [ADDR_W:0] in_num_pix,
`ifdef FSEQ_TEST_PATTERN_EN
    input  logic            in_test_mode,
`endif
    rgb_frame_seq_if.master bus,
    output logic            out_busy,
    output logic            out_frame_done,
    output logic            out_overrun
);
    localparam int                TWIDTH   = $clog2(FRAME_CLKS + 1);
    localparam logic [TWIDTH-1:0] T_RELOAD = TWIDTH'(FRAME_CLKS - 1);
    localparam logic [ADDR_W:0]   MAX_PIX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]       RST_WORD = 32'hC000_0000;

    // state      | meaning
    // IDLE       | waiting for in_enable    RD_REQ/RD_WAIT | RAM read, data captured
    // WR_PIX     | write pixel word         WR_RST         | write stream-reset word
    // WAIT_FRAME | wait for frame timer, or drop to IDLE when disabled
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_PIX, WR_RST, WAIT_FRAME} state_t;

    state_t            r_state, w_state_nxt, w_first;
    logic [TWIDTH-1:0] r_timer;
    logic [ADDR_W:0]   r_cnt, r_pix, w_pix_inc, w_num_clamp;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_hold;
    logic              r_late, r_test, w_test_in, w_start, w_full;
    logic [31:0]       w_pix_word;

    assign w_full      = bus.in_wr_fifo_full;
    assign w_pix_inc   = r_pix + 1'b1;
    assign w_num_clamp = (in_num_pix > MAX_PIX) ? MAX_PIX : in_num_pix;

`ifdef FSEQ_TEST_PATTERN_EN
    logic [7:0] r_frame_cnt, w_g;
    assign w_test_in  = in_test_mode;
    assign w_g        = 8'(r_pix);
    assign w_pix_word = r_test ? {8'h80, w_g, ~w_g, r_frame_cnt} : {8'h80, r_hold};

    always_ff @(posedge clk) begin
        if (rst)
            r_frame_cnt <= '0;
        else if (r_state == WR_RST && !w_full)
            r_frame_cnt <= r_frame_cnt + 8'd1;
    end
`else
    assign w_test_in  = 1'b0;
    assign w_pix_word = {8'h80, r_hold};
`endif

    always_comb begin
        w_first     = (w_num_clamp == '0) ? WR_RST : (w_test_in ? WR_PIX : RD_REQ);
        w_start     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_enable) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_first;
                end
            end
            RD_REQ:  w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = WR_PIX;
            WR_PIX: begin
                if (!w_full)
                    w_state_nxt = (w_pix_inc < r_cnt) ? (r_test ? WR_PIX : RD_REQ) : WR_RST;
            end
            WR_RST: begin
                if (!w_full)
                    w_state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!in_enable) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == '0) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_first;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from state; rst forces them low in the same clk.
    always_comb begin
        bus.out_pix_rd_en    = 1'b0;
        bus.out_pix_addr     = '0;
        bus.out_wr_fifo_en   = 1'b0;
        bus.out_wr_fifo_data = '0;
        out_busy             = 1'b0;
        out_frame_done       = 1'b0;
        out_overrun          = 1'b0;
        if (!rst) begin
            bus.out_pix_rd_en = (r_state == RD_REQ);
            bus.out_pix_addr  = r_addr;
            out_busy          = (r_state inside {RD_REQ, RD_WAIT, WR_PIX, WR_RST});
            out_overrun       = (r_state == WAIT_FRAME) && in_enable && r_late;
            if (r_state == WR_PIX) begin
                bus.out_wr_fifo_en   = !w_full;
                bus.out_wr_fifo_data = w_pix_word;
            end else if (r_state == WR_RST) begin
                bus.out_wr_fifo_en   = !w_full;
                bus.out_wr_fifo_data = RST_WORD;
                out_frame_done       = !w_full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_cnt   <= '0;
            r_pix   <= '0;
            r_addr  <= '0;
            r_hold  <= '0;
            r_late  <= 1'b0;
            r_test  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start)
                r_timer <= T_RELOAD;
            else if (r_timer != '0)
                r_timer <= r_timer - 1'b1;
            if (w_start) begin
                r_cnt  <= w_num_clamp;
                r_pix  <= '0;
                r_test <= w_test_in;
            end
            if (w_state_nxt == RD_REQ)
                r_addr <= w_start ? '0 : w_pix_inc[ADDR_W-1:0];
            if (r_state == RD_WAIT)
                r_hold <= bus.in_pix_data;
            if (r_state == WR_PIX && !w_full)
                r_pix <= w_pix_inc;
            // Late means the timer had already expired before this frame finished.
            if (r_state == WR_RST && !w_full)
                r_late <= (r_timer == '0);
        end
    end
endmodule
